branch_alloc_queue: RTL and testbench
=====================================

# branch_alloc_queue

Collects resolved branches from the NUM_IN branch execution units and feeds the branch predictor's single update port (`IN_branch*` of the predictor). Only allocation candidates are forwarded: taken branches that carried no predictor entry, i.e. branch ID all-ones. Candidates are filtered, de-duplicated by address against the queue and against each other, buffered in a small FIFO, and issued one per cycle. This keeps the single-port predictor from dropping or double-allocating entries when several branch units resolve in the same cycle.

## Interface
- NUM_IN, 2, number of branch execution units reporting per cycle
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ID_BITS, 6, predictor branch-ID width; all-ones = "no entry"
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- IN_valid  in  NUM_IN  per-unit resolved-branch valid
- IN_branchID  in  NUM_IN*ID_BITS  predictor ID attached at fetch (unit i at [i*ID_BITS +: ID_BITS])
- IN_branchAddr  in  NUM_IN*32  branch instruction address
- IN_branchDest  in  NUM_IN*32  resolved target
- IN_branchTaken  in  NUM_IN  resolved direction
- IN_branchIsJump  in  NUM_IN  unconditional jump
- IN_flush  in  1  discard all queued and incoming entries
- OUT_branchValid  out  1  update valid; predictor consumes it unconditionally
- OUT_branchID  out  ID_BITS  all-ones when valid, else 0
- OUT_branchAddr  out  32  head address, 0 when invalid
- OUT_branchDest  out  32  head target, 0 when invalid
- OUT_branchTaken  out  1  1 when valid, else 0
- OUT_branchIsJump  out  1  head jump flag, 0 when invalid
- OUT_full  out  1  count == DEPTH
- OUT_dropCount  out  16  saturating count of candidates lost to capacity

## Operation
- Candidate i: IN_valid[i] && IN_branchTaken[i] && IN_branchID[i] == all-ones. Non-candidates are ignored and not counted.
- Dedup:
  - Candidate i is discarded silently (not counted) if its IN_branchAddr equals the address of any occupied FIFO entry at cycle start, including the head being popped.
  - It is also discarded if it equals the address of a surviving candidate j < i.
- Enqueue: survivors are written in ascending input index at tail, tail+1, …
- Free slots = DEPTH − count + pop, where pop = (count != 0) && !IN_flush.
  - Survivors beyond the free slots are dropped.
  - OUT_dropCount += number dropped, saturating at 0xFFFF.
- Pop: when count != 0 and !IN_flush, the head is presented on OUT_* and removed at the clock edge. There is no backpressure.
- Outputs are combinational from head storage, gated: OUT_branchValid = (count != 0) && !IN_flush && !rst. Data fields are zeroed when not valid.
- Flush: in the IN_flush cycle, head/tail/count reset to 0, all inputs that cycle are discarded (not counted), OUT_dropCount is kept.
- State:
  - head, tail: log2(DEPTH) bits, wrapping modulo DEPTH.
  - count: log2(DEPTH)+1 bits.
  - next count = count − pop + enqueued.
- Reset: head = tail = count = 0, OUT_dropCount = 0. All outputs read 0 (OUT_full = 0).

## Timing
- Latency: a candidate at input in cycle N appears on OUT_branchValid in cycle N+1 if the queue was empty. Otherwise it appears after all older entries, at one per cycle.
- Throughput: 1 update per cycle out; up to NUM_IN per cycle in.
- Simultaneous pop and enqueue when full: the popped slot is reusable in the same cycle.
- Wrap-around: the tail write at index DEPTH−1 is followed by index 0. Multi-writes that straddle the wrap are split modulo DEPTH.
- Precedence: rst over IN_flush over enqueue/pop.
- rst or IN_flush mid-stream: no partial entry survives. OUT_branchValid is 0 in the flush cycle and the following cycle, unless new inputs arrive after the flush.

## Test plan
- Unit0: taken, ID 0x3F, addr 0x1000, dest 0x2000, jump 0 in cycle N.
  - Cycle N+1: OUT_branchValid = 1, ID 0x3F, addr 0x1000, dest 0x2000, taken 1.
  - Cycle N+2: OUT_branchValid = 0.
- Filtering: unit0 not taken with ID 0x3F, and unit1 taken with ID 0x05, same cycle.
  - No output ever; OUT_dropCount stays 0.
- Dedup: both units taken, ID 0x3F, addr 0x1000, same cycle.
  - Exactly one update issued.
  - Repeat with 0x1000 still queued: no second entry.
- Overflow, DEPTH = 4: three cycles of 2 distinct candidates each (6 addresses), starting empty.
  - Cycle 1: count 2.
  - Cycle 2: pop 1, enqueue 2, count 3.
  - Cycle 3: pop 1, free 2, enqueue 2, count 4, OUT_full = 1, OUT_dropCount = 0.
  - Cycle 4, 2 more candidates: free 1, OUT_dropCount = 1.
  - Outputs appear in arrival order with unit0 before unit1.
- Flush: queue holding 3 entries; assert IN_flush with 2 new candidates.
  - Flush cycle: OUT_branchValid = 0.
  - Next cycle: count 0, no output, OUT_dropCount unchanged.
- Saturation and reset:
  - Force more than 65535 capacity drops: OUT_dropCount holds at 0xFFFF.
  - rst: counter 0 and all outputs 0 on the next cycle.

Source files
------------

// File: rtl/branch_alloc_queue.sv
// Filters resolved taken branches lacking a predictor entry, de-duplicates them by address,
// buffers them in a small FIFO and issues one allocation update per cycle to the predictor.
module branch_alloc_queue #(
    parameter int NUM_IN  = 2,
    parameter int DEPTH   = 4,
    parameter int ID_BITS = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN-1:0]       IN_valid,
    input  logic [NUM_IN*ID_BITS-1:0] IN_branchID,
    input  logic [NUM_IN*32-1:0]    IN_branchAddr,
    input  logic [NUM_IN*32-1:0]    IN_branchDest,
    input  logic [NUM_IN-1:0]       IN_branchTaken,
    input  logic [NUM_IN-1:0]       IN_branchIsJump,
    input  logic                    IN_flush,
    output logic                    OUT_branchValid,
    output logic [ID_BITS-1:0]      OUT_branchID,
    output logic [31:0]             OUT_branchAddr,
    output logic [31:0]             OUT_branchDest,
    output logic                    OUT_branchTaken,
    output logic                    OUT_branchIsJump,
    output logic                    OUT_full,
    output logic [15:0]             OUT_dropCount
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]       addr_q [DEPTH];
    logic [31:0]       dest_q [DEPTH];
    logic [DEPTH-1:0]  jump_q;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [15:0]       drop_q, drop_d;

    logic              pop;
    logic [DEPTH-1:0]  occ;
    logic [NUM_IN-1:0] cand, surv, wr_en;
    logic [PW-1:0]     wr_idx [NUM_IN];
    logic [16:0]       drop_sum;
    int                free_slots, n_enq, n_drop;

    // Slot k is occupied when its distance from head is below count.
    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ[k] = ({1'b0, PW'(k) - head_q} < count_q);
        end
    end

    always_comb begin
        pop        = (count_q != '0) && !IN_flush;
        free_slots = DEPTH - int'(count_q) + int'(pop);
        n_enq      = 0;
        n_drop     = 0;
        cand       = '0;
        surv       = '0;
        wr_en      = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            wr_idx[i] = '0;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            cand[i] = IN_valid[i] && IN_branchTaken[i] &&
                      (IN_branchID[i*ID_BITS +: ID_BITS] == {ID_BITS{1'b1}});
            surv[i] = cand[i] && !IN_flush;
            for (int k = 0; k < DEPTH; k++) begin
                if (occ[k] && addr_q[k] == IN_branchAddr[i*32 +: 32]) surv[i] = 1'b0;
            end
            for (int j = 0; j < NUM_IN; j++) begin
                if (j < i && surv[j] && IN_branchAddr[j*32 +: 32] == IN_branchAddr[i*32 +: 32])
                    surv[i] = 1'b0;
            end
            if (surv[i]) begin
                if (n_enq < free_slots) begin
                    wr_en[i]  = 1'b1;
                    wr_idx[i] = tail_q + PW'(n_enq);
                    n_enq     = n_enq + 1;
                end else begin
                    n_drop = n_drop + 1;
                end
            end
        end

        drop_sum = {1'b0, drop_q} + 17'(n_drop);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        head_d   = head_q + PW'(pop);
        tail_d   = tail_q + PW'(n_enq);
        count_d  = count_q - CW'(pop) + CW'(n_enq);
        if (IN_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by head/count alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (!rst && wr_en[i]) begin
                addr_q[wr_idx[i]] <= IN_branchAddr[i*32 +: 32];
                dest_q[wr_idx[i]] <= IN_branchDest[i*32 +: 32];
                jump_q[wr_idx[i]] <= IN_branchIsJump[i];
            end
        end
    end

    // No backpressure: the predictor takes every valid update, so the head pops whenever it is shown.
    always_comb begin
        OUT_branchValid  = (count_q != '0) && !IN_flush && !rst;
        OUT_branchID     = OUT_branchValid ? {ID_BITS{1'b1}} : '0;
        OUT_branchAddr   = OUT_branchValid ? addr_q[head_q] : 32'h0;
        OUT_branchDest   = OUT_branchValid ? dest_q[head_q] : 32'h0;
        OUT_branchTaken  = OUT_branchValid;
        OUT_branchIsJump = OUT_branchValid && jump_q[head_q];
        OUT_full         = (count_q == CW'(DEPTH));
        OUT_dropCount    = drop_q;
    end
endmodule

// File: tb/tb_branch_alloc_queue.sv
// Vector table plus scoreboard bench for branch_alloc_queue, followed by hand-written
// reset, flush and drop-counter saturation sequences.
module tb_branch_alloc_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  IN_valid, IN_branchTaken, IN_branchIsJump;
    logic [11:0] IN_branchID;
    logic [63:0] IN_branchAddr, IN_branchDest;
    logic        IN_flush;
    logic        OUT_branchValid, OUT_branchTaken, OUT_branchIsJump, OUT_full;
    logic [5:0]  OUT_branchID;
    logic [31:0] OUT_branchAddr, OUT_branchDest;
    logic [15:0] OUT_dropCount;

    branch_alloc_queue #(.NUM_IN(2), .DEPTH(DEPTH), .ID_BITS(6)) dut (
        .clk(clk), .rst(rst),
        .IN_valid(IN_valid), .IN_branchID(IN_branchID), .IN_branchAddr(IN_branchAddr),
        .IN_branchDest(IN_branchDest), .IN_branchTaken(IN_branchTaken),
        .IN_branchIsJump(IN_branchIsJump), .IN_flush(IN_flush),
        .OUT_branchValid(OUT_branchValid), .OUT_branchID(OUT_branchID),
        .OUT_branchAddr(OUT_branchAddr), .OUT_branchDest(OUT_branchDest),
        .OUT_branchTaken(OUT_branchTaken), .OUT_branchIsJump(OUT_branchIsJump),
        .OUT_full(OUT_full), .OUT_dropCount(OUT_dropCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0, t0, j0, v1, t1, j1, flush;
        logic [5:0]  id0, id1;
        logic [31:0] a0, d0, a1, d1;
        logic        acc0, acc1;
        int          drops;
    } vec_t;

    vec_t        vecs[$];
    logic [64:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          exp_drop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic v0, t0, input logic [5:0] id0, input logic [31:0] a0, d0,
                                input logic j0, v1, t1, input logic [5:0] id1, input logic [31:0] a1, d1,
                                input logic j1, flush, acc0, acc1, input int drops);
        vec_t v;
        v.v0 = v0; v.t0 = t0; v.id0 = id0; v.a0 = a0; v.d0 = d0; v.j0 = j0;
        v.v1 = v1; v.t1 = t1; v.id1 = id1; v.a1 = a1; v.d1 = d1; v.j1 = j1;
        v.flush = flush; v.acc0 = acc0; v.acc1 = acc1; v.drops = drops;
        return v;
    endfunction

    function automatic vec_t idle_v();
        return mk(0, 0, 6'h0, 0, 0, 0, 0, 0, 6'h0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t pair(input logic [31:0] a0, a1, input logic flush, acc0, acc1, input int drops);
        return mk(1, 1, 6'h3F, a0, $urandom, 1'($urandom_range(0, 1)),
                  1, 1, 6'h3F, a1, $urandom, 1'($urandom_range(0, 1)), flush, acc0, acc1, drops);
    endfunction

    task automatic drive(input vec_t v);
        IN_valid        = {v.v1, v.v0};
        IN_branchTaken  = {v.t1, v.t0};
        IN_branchIsJump = {v.j1, v.j0};
        IN_branchID     = {v.id1, v.id0};
        IN_branchAddr   = {v.a1, v.a0};
        IN_branchDest   = {v.d1, v.d0};
        IN_flush        = v.flush;
    endtask

    task automatic check_outputs(input logic flush_now);
        logic        expv;
        logic [64:0] e;
        expv = (exp_q.size() != 0) && !flush_now;
        chk("valid", 64'(OUT_branchValid), 64'(expv));
        if (expv) begin
            e = exp_q[0];
            chk("addr", 64'(OUT_branchAddr), 64'(e[64:33]));
            chk("dest", 64'(OUT_branchDest), 64'(e[32:1]));
            chk("jump", 64'(OUT_branchIsJump), 64'(e[0]));
            chk("id", 64'(OUT_branchID), 64'h3F);
            chk("taken", 64'(OUT_branchTaken), 64'h1);
        end else begin
            chk("idle_fields", {OUT_branchID, OUT_branchAddr, OUT_branchTaken, OUT_branchIsJump}, 64'h0);
            chk("idle_dest", 64'(OUT_branchDest), 64'h0);
        end
        chk("full", 64'(OUT_full), 64'(exp_q.size() == DEPTH));
        chk("drop_count", 64'(OUT_dropCount), 64'(exp_drop));
        if (flush_now) exp_q.delete();
        else if (expv) void'(exp_q.pop_front());
    endtask

    task automatic run_vec(input vec_t v);
        drive(v);
        @(negedge clk);
        check_outputs(v.flush);
        if (v.acc0) exp_q.push_back({v.a0, v.d0, v.j0});
        if (v.acc1) exp_q.push_back({v.a1, v.d1, v.j1});
        exp_drop += v.drops;
        @(posedge clk);
        #1;
        drive(idle_v());
    endtask

    initial begin
        rst = 1'b1;
        drive(idle_v());
        @(negedge clk);
        chk("rst_valid", 64'(OUT_branchValid), 64'h0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_drop", 64'(OUT_dropCount), 64'h0);
        chk("rst_full", 64'(OUT_full), 64'h0);

        // single candidate: shows next cycle, gone the cycle after
        vecs.push_back(mk(1, 1, 6'h3F, 32'h1000, 32'h2000, 0, 0, 0, 6'h0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(idle_v());
        vecs.push_back(idle_v());
        // filtering: not taken, and taken with a real predictor ID
        vecs.push_back(mk(1, 0, 6'h3F, 32'h3000, 32'h1, 0, 1, 1, 6'h05, 32'h3004, 32'h2, 0, 0, 0, 0, 0));
        vecs.push_back(idle_v());
        // dedup within a cycle, then against the popping head
        vecs.push_back(pair(32'h1000, 32'h1000, 0, 1, 0, 0));
        vecs.push_back(pair(32'h1000, 32'h1000, 0, 0, 0, 0));
        vecs.push_back(idle_v());
        // overflow: fill to four, then lose one candidate to capacity
        vecs.push_back(pair(32'hA000, 32'hA004, 0, 1, 1, 0));
        vecs.push_back(pair(32'hA008, 32'hA00C, 0, 1, 1, 0));
        vecs.push_back(pair(32'hA010, 32'hA014, 0, 1, 1, 0));
        vecs.push_back(pair(32'hA018, 32'hA01C, 0, 1, 0, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(idle_v());
        // flush with three queued entries and two new candidates
        vecs.push_back(pair(32'hB000, 32'hB004, 0, 1, 1, 0));
        vecs.push_back(pair(32'hB008, 32'hB00C, 0, 1, 1, 0));
        vecs.push_back(pair(32'hB010, 32'hB014, 1, 0, 0, 0));
        vecs.push_back(idle_v());
        vecs.push_back(idle_v());

        foreach (vecs[i]) run_vec(vecs[i]);
        chk("sb_empty", 64'(exp_q.size()), 64'h0);

        // reset mid-stream discards queued and incoming entries and clears the counter
        drive(pair(32'hC000, 32'hC004, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(pair(32'hC008, 32'hC00C, 0, 0, 0, 0));
        @(negedge clk);
        chk("rst_mid_valid", 64'(OUT_branchValid), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(idle_v());
        @(negedge clk);
        chk("post_rst_valid", 64'(OUT_branchValid), 64'h0);
        chk("post_rst_drop", 64'(OUT_dropCount), 64'h0);
        chk("post_rst_full", 64'(OUT_full), 64'h0);

        // saturation: a full queue drops one of two new candidates every cycle
        @(posedge clk);
        #1;
        for (int k = 0; k < 65545; k++) begin
            if (k == 13) chk("drop_after_13", 64'(OUT_dropCount), 64'd10);
            drive(pair(32'h0010_0000 + 32'(k) * 8, 32'h0010_0004 + 32'(k) * 8, 0, 0, 0, 0));
            @(posedge clk);
            #1;
        end
        drive(idle_v());
        @(negedge clk);
        chk("drop_saturated", 64'(OUT_dropCount), 64'hFFFF);
        chk("sat_full", 64'(OUT_full), 64'h1);
        @(posedge clk);
        #1;
        drive(pair(32'hD000, 32'hD004, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        drive(idle_v());
        @(negedge clk);
        chk("drop_held", 64'(OUT_dropCount), 64'hFFFF);

        // final reset returns everything to zero
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("final_drop", 64'(OUT_dropCount), 64'h0);
        chk("final_full", 64'(OUT_full), 64'h0);
        chk("final_valid", 64'(OUT_branchValid), 64'h0);
        chk("final_fields", {OUT_branchID, OUT_branchAddr, OUT_branchTaken, OUT_branchIsJump}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
